// File: rtl/parking_meter_timer.sv
// Parking-meter remaining-time counter with coin/preset events, saturation and blink control.
// Latency: an event on one clock edge is visible on time_out after that edge; sec_tick is decoded from the prescaler.
// Backpressure: none; level inputs are edge-detected and the countdown freezes while en=0.
module parking_meter_timer #(
    parameter int WIDTH      = 14,
    parameter int MAX_VAL    = 9999,
    parameter int TICK_DIV   = 100_000_000,
    parameter int LOW_THRESH = 200,
    parameter int ADD0       = 50,
    parameter int ADD1       = 150,
    parameter int ADD2       = 200,
    parameter int ADD3       = 500,
    parameter int PRE0       = 10,
    parameter int PRE1       = 205
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       preset,
    input  logic [3:0]       add,
    output logic [WIDTH-1:0] time_out,
    output logic             expired,
    output logic             display_on,
    output logic             sec_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    P_HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [PW-1:0]    P_ONE  = PW'(1);
    localparam logic [WIDTH:0]   S_ONE  = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0]   S_MAX  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   S_ADD0 = (WIDTH + 1)'(ADD0);
    localparam logic [WIDTH:0]   S_ADD1 = (WIDTH + 1)'(ADD1);
    localparam logic [WIDTH:0]   S_ADD2 = (WIDTH + 1)'(ADD2);
    localparam logic [WIDTH:0]   S_ADD3 = (WIDTH + 1)'(ADD3);
    localparam logic [WIDTH-1:0] T_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] T_LOW  = WIDTH'(LOW_THRESH);
    localparam logic [WIDTH-1:0] T_PRE0 = WIDTH'(PRE0);
    localparam logic [WIDTH-1:0] T_PRE1 = WIDTH'(PRE1);

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_nxt;
    logic [1:0]       preset_q;
    logic [3:0]       add_q;
    logic             armed;
    logic [1:0]       preset_ev;
    logic [3:0]       add_ev;
    logic [WIDTH:0]   amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] time_nxt;
    logic             blink_nxt;
    logic             half_pt;
    logic             preset_hit;

    assign sec_tick = (presc == P_LAST);

    // The first edge after reset only samples history, so inputs held through reset need a fresh rise.
    assign preset_ev = preset & ~preset_q & {2{armed}};
    assign add_ev    = add & ~add_q & {4{armed}};

    always_comb begin
        amt        = '0;
        sum        = '0;
        time_nxt   = time_out;
        presc_nxt  = presc;
        blink_nxt  = display_on;
        half_pt    = 1'b0;
        preset_hit = |preset_ev;

        if (en) begin
            presc_nxt = sec_tick ? '0 : presc + P_ONE;
            half_pt   = (presc == P_HALF) || sec_tick;
        end

        if (add_ev[0])      amt = S_ADD0;
        else if (add_ev[1]) amt = S_ADD1;
        else if (add_ev[2]) amt = S_ADD2;
        else if (add_ev[3]) amt = S_ADD3;

        sum = {1'b0, time_out} + amt;
        if (sec_tick && en && (sum != '0)) begin
            sum = sum - S_ONE;
        end
        time_nxt = (sum > S_MAX) ? T_MAX : sum[WIDTH-1:0];

        if (preset_ev[0]) begin
            time_nxt  = T_PRE0;
            presc_nxt = '0;
        end else if (preset_ev[1]) begin
            time_nxt  = T_PRE1;
            presc_nxt = '0;
        end

        // Blink: steady above threshold, restart lit when leaving steady, 1 Hz when low, 0.5 Hz at zero.
        if (time_nxt >= T_LOW) begin
            blink_nxt = 1'b1;
        end else if (time_out >= T_LOW) begin
            blink_nxt = 1'b1;
        end else if (!preset_hit) begin
            if ((time_nxt != '0) && half_pt) begin
                blink_nxt = ~display_on;
            end else if ((time_nxt == '0) && en && sec_tick) begin
                blink_nxt = ~display_on;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_out   <= '0;
            expired    <= 1'b1;
            display_on <= 1'b1;
            presc      <= '0;
            preset_q   <= '0;
            add_q      <= '0;
            armed      <= 1'b0;
        end else begin
            time_out   <= time_nxt;
            expired    <= (time_nxt == '0);
            display_on <= blink_nxt;
            presc      <= presc_nxt;
            preset_q   <= preset;
            add_q      <= add;
            armed      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parking_meter_timer.sv
// Directed bench for parking_meter_timer with a 4-cycle second; inputs change and outputs are sampled on falling edges.
module tb_parking_meter_timer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  preset;
    logic [3:0]  add;
    logic [13:0] time_out;
    logic        expired;
    logic        display_on;
    logic        sec_tick;

    int total = 0;
    int bad   = 0;

    parking_meter_timer #(
        .WIDTH(14), .MAX_VAL(9999), .TICK_DIV(4), .LOW_THRESH(200),
        .ADD0(50), .ADD1(150), .ADD2(200), .ADD3(500), .PRE0(10), .PRE1(205)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .preset(preset), .add(add),
        .time_out(time_out), .expired(expired), .display_on(display_on), .sec_tick(sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_add(input int i);
        add[i] = 1'b1;
        @(negedge clk);
        add = '0;
        @(negedge clk);
    endtask

    task automatic pulse_preset(input int i);
        preset[i] = 1'b1;
        @(negedge clk);
        preset = '0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; preset = '0; add = '0;
        repeat (2) @(negedge clk);
        chk("rst_time", time_out, 0);
        chk("rst_expired", expired, 1);
        chk("rst_display", display_on, 1);
        chk("rst_tick", sec_tick, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: reset mid-second aborts state; add[0] held through reset does not fire
        pulse_add(3);
        chk("t1_500", time_out, 500);
        chk("t1_not_expired", expired, 0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; add = 4'b0001;
        #1;
        chk("t1_async_time", time_out, 0);
        chk("t1_async_expired", expired, 1);
        chk("t1_async_display", display_on, 1);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_held_add_no_event", time_out, 0);
        chk("t1_held_expired", expired, 1);
        add = '0;
        @(negedge clk);

        // Test 2: preset[1] held 10 cycles loads once, then counts down every 4 cycles
        preset = 2'b10; en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("t2_time", time_out, 205 - (k - 1) / 4);
            chk("t2_tick", sec_tick, (k % 4 == 0) ? 1 : 0);
        end
        preset = '0; en = 1'b0;

        // Test 3: saturation at 9999, tick at max, add at max
        pulse_preset(0);
        chk("t3_pre0", time_out, 10);
        for (int i = 0; i < 19; i++) pulse_add(3);
        chk("t3_9510", time_out, 9510);
        pulse_add(3);
        chk("t3_sat", time_out, 9999);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_tick_seen", sec_tick, 1);
        chk("t3_pre_tick", time_out, 9999);
        @(negedge clk);
        chk("t3_9998", time_out, 9998);
        repeat (392) @(negedge clk);
        chk("t3_9900", time_out, 9900);
        en = 1'b0;
        pulse_add(3);
        chk("t3_9900_add3", time_out, 9999);
        pulse_add(2);
        chk("t3_max_add2", time_out, 9999);

        // Test 4: add coincident with a tick at zero; tick alone at zero
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_tick", sec_tick, 1);
        chk("t4_zero_expired", expired, 1);
        add = 4'b0001;
        @(negedge clk);
        add = '0;
        chk("t4_add_tick", time_out, 49);
        chk("t4_expired_clear", expired, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t4_zero_hold", time_out, 0);
        chk("t4_zero_expired2", expired, 1);

        // Test 5: add priority, preset over add, en=0 freeze
        en = 1'b0;
        pulse_preset(0);
        chk("t5_pre0", time_out, 10);
        add = 4'b1001;
        @(negedge clk);
        add = '0;
        @(negedge clk);
        chk("t5_low_idx_wins", time_out, 60);
        preset = 2'b01; add = 4'b1000;
        @(negedge clk);
        preset = '0; add = '0;
        @(negedge clk);
        chk("t5_preset_wins", time_out, 10);
        repeat (20) @(negedge clk);
        chk("t5_frozen", time_out, 10);
        chk("t5_frozen_tick", sec_tick, 0);
        pulse_add(3);
        chk("t5_510", time_out, 510);
        chk("t5_disp_steady", display_on, 1);
        pulse_preset(0);
        chk("t5_back_10", time_out, 10);
        chk("t5_disp_enter", display_on, 1);

        // Test 6: 1 Hz blink while low, 0.5 Hz at zero, steady after a large add
        en = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            chk("t6_time", time_out, (k >= 40) ? 0 : 10 - k / 4);
            chk("t6_disp", display_on, (k <= 40) ? (((k / 2) % 2 == 0) ? 1 : 0)
                                                 : (((k / 4) % 2 == 0) ? 1 : 0));
        end
        add = 4'b1000;
        @(negedge clk);
        add = '0;
        chk("t6_add_time", time_out, 500);
        chk("t6_add_disp", display_on, 1);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("t6_steady_disp", display_on, 1);
            chk("t6_steady_time", time_out, (j >= 3) ? 499 : 500);
        end
        chk("t6_expired", expired, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
